vc_fifo: RTL and testbench

- Per-virtual-channel FIFO that sits on both sides of the transaction-layer arbiter.
- It receives push/pop strobes from the arbiter and returns empty/almost_full status that the arbiter uses to decide those strobes.
- Four instances form one VC bank: the arbiter pops source FIFOs and pushes destination FIFOs.
- The block holds 12-bit TLP words, reports occupancy, and flags overflow and underflow misuse.

---
 rtl/vc_fifo_pkg.sv | 11 +
 rtl/vc_fifo_if.sv | 33 +++
 rtl/vc_fifo_mem.sv | 37 +++
 rtl/vc_fifo.sv | 89 ++++++++
 tb/tb_vc_fifo.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/vc_fifo_pkg.sv
// Shared VC-bank constants: TLP word width, channel count, default FIFO geometry and thresholds.
// Used by the per-VC FIFO, the transaction-layer arbiter and the bank wrapper.
package vc_fifo_pkg;
  localparam int TLP_WIDTH     = 12;
  localparam int VC_COUNT      = 4;
  localparam int FIFO_AW       = 3;
  localparam int AF_THRESH_DEF = 6;
  localparam int AE_THRESH_DEF = 1;

  typedef logic [TLP_WIDTH-1:0] tlp_word_t;
endpackage

// File: rtl/vc_fifo_if.sv
// Arbiter <-> VC FIFO bundle: push/pop strobes and write data in, read data and status out.
// master = arbiter side, slave = FIFO side.
interface vc_fifo_if
  import vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = TLP_WIDTH,
  parameter int ADDR_WIDTH = FIFO_AW
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output data_in, push, pop,
    input  data_out, valid_out, empty, full, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  data_in, push, pop,
    output data_out, valid_out, empty, full, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/vc_fifo_mem.sv
// DEPTH x DATA_WIDTH register array, synchronous write and registered read (1-cycle latency).
// Storage is never reset; only the read register clears so data_out starts at zero.
module vc_fifo_mem #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Same-edge write to raddr returns the old word, which is the oldest entry when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/vc_fifo.sv
// Per-VC FIFO: pointer/count control and status decode around vc_fifo_mem; 1-cycle read latency.
// Flags decode the registered count, so the arbiter sees them one cycle after the accepting edge.
module vc_fifo
  import vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = TLP_WIDTH,
  parameter int ADDR_WIDTH = FIFO_AW,
  parameter int AF_THRESH  = AF_THRESH_DEF,
  parameter int AE_THRESH  = AE_THRESH_DEF
) (
  input  logic      clk,
  input  logic      reset,
  vc_fifo_if.slave  bus
);
  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  valid_q;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  empty, full;
  logic                  push_acc, pop_acc;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign push_acc = bus.push && (!full || bus.pop);
  assign pop_acc  = bus.pop && !empty;

  always_comb begin
    wr_ptr_d    = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop_acc  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    if (push_acc && !pop_acc) begin
      count_d = count_q + 1'b1;
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - 1'b1;
    end
    overflow_d  = overflow_q  || (bus.push && !push_acc);
    underflow_d = underflow_q || (bus.pop && empty);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= pop_acc;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  vc_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (reset),
    .we    (push_acc),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .re    (pop_acc),
    .raddr (rd_ptr_q),
    .rdata (bus.data_out)
  );

  assign bus.valid_out    = valid_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_vc_fifo.sv
// Randomized and directed bench for vc_fifo against a queue-based reference model.
module tb_vc_fifo;
  localparam int DW    = 12;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic reset;

  vc_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  vc_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_valid;
  logic          exp_ovf;
  logic          exp_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = model_q.size();
    check({tag, ":count"},  32'(bus.count),        32'(n));
    check({tag, ":empty"},  32'(bus.empty),        32'(n == 0));
    check({tag, ":full"},   32'(bus.full),         32'(n == DEPTH));
    check({tag, ":afull"},  32'(bus.almost_full),  32'(n >= AF));
    check({tag, ":aempty"}, 32'(bus.almost_empty), 32'(n <= AE));
    check({tag, ":valid"},  32'(bus.valid_out),    32'(exp_valid));
    check({tag, ":dout"},   32'(bus.data_out),     32'(exp_dout));
    check({tag, ":ovf"},    32'(bus.overflow),     32'(exp_ovf));
    check({tag, ":unf"},    32'(bus.underflow),    32'(exp_unf));
  endtask

  // Drive at the falling edge, advance one rising edge, update the model, check at the next falling edge.
  task automatic cycle(input logic p, input logic r, input logic [DW-1:0] d, input string tag);
    int  n;
    logic pop_ok, push_ok;
    bus.push    = p;
    bus.pop     = r;
    bus.data_in = d;
    @(posedge clk);
    n       = model_q.size();
    pop_ok  = r && (n > 0);
    push_ok = p && ((n < DEPTH) || r);
    if (p && !push_ok) exp_ovf = 1'b1;
    if (r && n == 0)   exp_unf = 1'b1;
    exp_valid = pop_ok;
    if (pop_ok)  exp_dout = model_q.pop_front();
    if (push_ok) model_q.push_back(d);
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    check_all(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all({tag, ":async"});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all({tag, ":post"});
  endtask

  initial begin
    logic [DW-1:0] w;
    int pp, rp;

    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    reset       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b1;
    @(negedge clk);
    check_all("idle");

    // Fill 0x001..0x008, then one push into a full FIFO
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, DW'(i), "fill");
    check("fill_full", 32'(bus.full), 32'd1);
    cycle(1'b1, 1'b0, 12'hFFF, "ovf_push");
    check("ovf_count", 32'(bus.count), 32'd8);

    // Drain in order, then pop from empty
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, '0, "drain");
      check("drain_seq", 32'(bus.data_out), 32'(i));
    end
    cycle(1'b0, 1'b1, '0, "unf_pop");
    check("unf_hold", 32'(bus.data_out), 32'h008);

    // Move pointers past the wrap, settle at count 3, then concurrent push+pop
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, DW'(12'h100 + i), "wrap_fill");
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, '0, "wrap_drain");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, DW'(12'h200 + i), "wrap_pre");
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, DW'(12'h300 + i), "wrap_both");
    check("wrap_count", 32'(bus.count), 32'd3);

    // Concurrent push+pop while full
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(12'h400 + i), "fb_fill");
    cycle(1'b1, 1'b1, 12'hABC, "fb_both");
    check("fb_count", 32'(bus.count), 32'd8);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0, "fb_drain");
    check("fb_last", 32'(bus.data_out), 32'hABC);

    // Asynchronous reset with words in flight
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(12'h500 + i), "ar_fill");
    async_reset_pulse("ar");
    cycle(1'b1, 1'b0, 12'h055, "ar_push");
    cycle(1'b0, 1'b1, '0, "ar_pop");
    check("ar_data", 32'(bus.data_out), 32'h055);

    // Random traffic with phase-varying push/pop bias and occasional resets
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        pp = $urandom_range(20, 90);
        rp = $urandom_range(20, 90);
      end
      w = DW'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        async_reset_pulse("rnd");
      end else begin
        cycle(($urandom_range(0, 99) < pp), ($urandom_range(0, 99) < rp), w, "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
